// File: rtl/fir_poly_pkg.sv
// -----------------------------------------------------------------------------
// fir_poly_pkg
//   Shared types and constants for the 4-phase polyphase FIR input commutator.
//
//   Contents
//     SAMPLE_W      sample magnitude width (bits)
//     NUM_PHASES    number of polyphase lanes
//     phase_t       2-bit lane index / phase counter type
//     poly_frame_t  one complete frame: four lanes plus frame polarity
//     LAST_PHASE    index of the lane that completes a frame
//     next_phase()  round-robin successor of a phase index
// -----------------------------------------------------------------------------
package fir_poly_pkg;

   localparam int SAMPLE_W   = 33;
   localparam int NUM_PHASES = 4;

   typedef logic [1:0] phase_t;

   // Packed so a whole frame can be registered, muxed and reset as one vector.
   // lane[0] holds the first (phase-0) sample of the frame.
   typedef struct packed {
      logic [NUM_PHASES-1:0][SAMPLE_W-1:0] lane;
      logic                                sign;
   } poly_frame_t;

   localparam phase_t LAST_PHASE = phase_t'(NUM_PHASES - 1);

   // Wraps naturally because phase_t is exactly log2(NUM_PHASES) bits wide.
   function automatic phase_t next_phase(input phase_t p);
      return p + phase_t'(1);
   endfunction

endpackage

// File: rtl/poly_frame_reg.sv
// -----------------------------------------------------------------------------
// poly_frame_reg
//   Single-entry valid/ready register stage carrying a poly_frame_t.
//   Accepts a new frame whenever it is empty or its current frame is being
//   consumed in the same cycle, so a full-rate stream passes without bubbles.
//   The registered frame is held unchanged while out_valid_o & !out_ready_i.
//
//   Ports
//     clk          clock, rising edge
//     rst          synchronous active-high reset (empties the stage, zeroes data)
//     in_valid_i   upstream offers in_frame_i
//     in_ready_o   stage can take a frame this cycle
//     in_frame_i   frame offered by upstream
//     out_valid_o  out_frame_o holds a valid frame
//     out_ready_i  downstream consumes out_frame_o this cycle
//     out_frame_o  registered frame
// -----------------------------------------------------------------------------
module poly_frame_reg
   import fir_poly_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  poly_frame_t in_frame_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output poly_frame_t out_frame_o
);

   logic        valid_q;
   logic        valid_d;
   poly_frame_t frame_q;
   poly_frame_t frame_d;
   logic        load;

   // Ready depends on out_ready_i so replacement happens in a single edge.
   assign in_ready_o = ~valid_q | out_ready_i;
   assign load       = in_valid_i & in_ready_o;

   always_comb begin
      valid_d = valid_q;
      frame_d = frame_q;
      if (load) begin
         valid_d = 1'b1;
         frame_d = in_frame_i;
      end else if (out_ready_i) begin
         // Data is left in place after consumption; only valid drops.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         frame_q <= '0;
      end else begin
         valid_q <= valid_d;
         frame_q <= frame_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_frame_o = frame_q;

endmodule

// File: rtl/poly_phase_splitter.sv
// -----------------------------------------------------------------------------
// poly_phase_splitter
//   Input commutator for the 4-phase polyphase FIR. Samples arriving one per
//   handshake are dealt round-robin into four lanes of a fill buffer; a
//   complete frame (plus the polarity latched with its phase-0 sample) is
//   handed to a registered output stage feeding the four phase sub-filters.
//   Fill buffer + output stage form a double buffer, so frame N+1 fills while
//   frame N waits to be consumed.
//
//   Optional feature (macro POLY_SPLIT_FLUSH_EN):
//     adds the flush input, which closes a partial frame by zeroing its
//     unfilled lanes and treating it as complete. Without the macro there is
//     no flush port and partial frames are only discarded by rst.
//
//   Ports
//     clk                 clock, rising edge
//     rst                 synchronous active-high reset
//     in_data / in_sign   input sample / frame polarity (used with phase-0 only)
//     in_valid / in_ready input handshake
//     out_data_0..3       lanes of the presented frame (0 = first sample)
//     poly_sign           polarity of the presented frame
//     out_valid/out_ready frame handshake
//     flush               (POLY_SPLIT_FLUSH_EN only) close the partial frame
// -----------------------------------------------------------------------------
module poly_phase_splitter
   import fir_poly_pkg::*;
#(
   parameter int DW = SAMPLE_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_sign,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data_0,
   output logic [DW-1:0] out_data_1,
   output logic [DW-1:0] out_data_2,
   output logic [DW-1:0] out_data_3,
   output logic          poly_sign,
   output logic          out_valid,
`ifdef POLY_SPLIT_FLUSH_EN
   input  logic          flush,
`endif
   input  logic          out_ready
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   phase_t      phase_q;
   phase_t      phase_d;
   poly_frame_t fill_q;
   poly_frame_t fill_d;
   logic        full_q;     // completed frame waiting for the output stage
   logic        full_d;

   // ---------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------
   logic        flush_req;
   logic        flush_fire;
   logic        sample_xfer;
   logic        frame_done;
   logic        stage_valid;
   logic        stage_ready;
   poly_frame_t stage_frame;

   logic [NUM_PHASES-1:0][SAMPLE_W-1:0] lane_d;
   logic                                sign_d;

`ifdef POLY_SPLIT_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   // While a completed frame is parked in the fill buffer no new sample may
   // overwrite it. A flush request also blocks input for its cycle so the
   // flush and a sample never compete for the same edge.
   assign in_ready    = ~full_q & ~flush_req;
   assign sample_xfer = in_valid & in_ready;

   // Flushing an empty frame (phase 0) or a frame already parked is a no-op.
   assign flush_fire  = flush_req & (phase_q != '0) & ~full_q;

   assign frame_done  = (sample_xfer & (phase_q == LAST_PHASE)) | flush_fire;

   // ---------------------------------------------------------------------
   // Fill buffer lane next-state: write the addressed lane on a sample,
   // zero the not-yet-written lanes (index >= phase) on a flush.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PHASES; gi++) begin : g_lane
         assign lane_d[gi] =
            (sample_xfer && (phase_q == phase_t'(gi))) ? SAMPLE_W'(in_data) :
            (flush_fire  && (phase_q <= phase_t'(gi))) ? '0                 :
                                                         fill_q.lane[gi];
      end
   endgenerate

   assign sign_d = (sample_xfer && (phase_q == '0)) ? in_sign : fill_q.sign;
   assign fill_d = {lane_d, sign_d};

   always_comb begin
      phase_d = phase_q;
      if (sample_xfer) begin
         phase_d = next_phase(phase_q);
      end else if (flush_fire) begin
         phase_d = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Hand-off to the output stage. A frame completing this cycle is offered
   // straight away (fill_d already contains the final lane), giving zero
   // bubble latency. When full_q is set no sample or flush can occur, so
   // fill_d equals the parked frame and the same path serves both cases.
   // ---------------------------------------------------------------------
   assign stage_valid = full_q | frame_done;
   assign stage_frame = fill_d;
   assign full_d      = stage_valid & ~stage_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
         fill_q  <= '0;
         full_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         fill_q  <= fill_d;
         full_q  <= full_d;
      end
   end

   // ---------------------------------------------------------------------
   // Output stage
   // ---------------------------------------------------------------------
   poly_frame_t out_frame;

   poly_frame_reg u_out_stage (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (stage_valid),
      .in_ready_o  (stage_ready),
      .in_frame_i  (stage_frame),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_frame_o (out_frame)
   );

   assign out_data_0 = DW'(out_frame.lane[0]);
   assign out_data_1 = DW'(out_frame.lane[1]);
   assign out_data_2 = DW'(out_frame.lane[2]);
   assign out_data_3 = DW'(out_frame.lane[3]);
   assign poly_sign  = out_frame.sign;

endmodule

// File: tb/tb_poly_phase_splitter.sv
// -----------------------------------------------------------------------------
// tb_poly_phase_splitter
//   Self-checking bench: reset checks, a table of directed cycle vectors,
//   hand-written reset-mid-frame (and flush, when POLY_SPLIT_FLUSH_EN is
//   defined) sequences, then randomized traffic compared against a
//   frame-level reference model built from queues.
// -----------------------------------------------------------------------------
module tb_poly_phase_splitter;

   localparam int DW = 33;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_data;
   logic          in_sign;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data_0, out_data_1, out_data_2, out_data_3;
   logic          poly_sign;
   logic          out_valid;
   logic          out_ready;
   logic          flush;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   poly_phase_splitter #(.DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sign    (in_sign),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data_0 (out_data_0),
      .out_data_1 (out_data_1),
      .out_data_2 (out_data_2),
      .out_data_3 (out_data_3),
      .poly_sign  (poly_sign),
      .out_valid  (out_valid),
`ifdef POLY_SPLIT_FLUSH_EN
      .flush      (flush),
`endif
      .out_ready  (out_ready)
   );

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_frame(input string name, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input logic [DW-1:0] e2, input logic [DW-1:0] e3, input logic es);
      chk({name, " d0"}, 64'(out_data_0), 64'(e0));
      chk({name, " d1"}, 64'(out_data_1), 64'(e1));
      chk({name, " d2"}, 64'(out_data_2), 64'(e2));
      chk({name, " d3"}, 64'(out_data_3), 64'(e3));
      chk({name, " sign"}, 64'(poly_sign), 64'(es));
   endtask

   // Apply inputs for one cycle, clock, then settle past the edge.
   task automatic step(input logic iv, input logic [DW-1:0] d, input logic s, input logic ordy);
      in_valid  = iv;
      in_data   = d;
      in_sign   = s;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_sign = 1'b0; out_ready = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Directed vector table
   // ---------------------------------------------------------------------
   typedef struct packed {
      logic          iv;
      logic [DW-1:0] d;
      logic          s;
      logic          ordy;
      logic          e_ov;
      logic          e_ir;
      logic [DW-1:0] e0, e1, e2, e3;
      logic          e_sg;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic iv, input int d, input logic s, input logic ordy,
                               input logic e_ov, input logic e_ir,
                               input int e0, input int e1, input int e2, input int e3,
                               input logic e_sg);
      vec_t v;
      v.iv = iv; v.d = DW'(d); v.s = s; v.ordy = ordy;
      v.e_ov = e_ov; v.e_ir = e_ir;
      v.e0 = DW'(e0); v.e1 = DW'(e1); v.e2 = DW'(e2); v.e3 = DW'(e3);
      v.e_sg = e_sg;
      return v;
   endfunction

   // ---------------------------------------------------------------------
   // Reference model types
   // ---------------------------------------------------------------------
   typedef struct packed {
      logic [3:0][DW-1:0] d;
      logic               s;
   } frame_t;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      frame_t        exp_q [$];
      logic [DW-1:0] part  [$];
      logic          part_sign;
      frame_t        f;
      logic          sx, fx;
      int            nframes;

      // Stream 1..4; 10..17 under stall with signs 1,0,0,0 / 0,1,1,1 and an
      // extra sample offered while blocked; then 20..23 to show phase is intact.
      vecs[0]  = mk(1,  1, 1, 1,  0, 1,  0, 0, 0, 0, 0);
      vecs[1]  = mk(1,  2, 0, 1,  0, 1,  0, 0, 0, 0, 0);
      vecs[2]  = mk(1,  3, 0, 1,  0, 1,  0, 0, 0, 0, 0);
      vecs[3]  = mk(1,  4, 0, 1,  1, 1,  1, 2, 3, 4, 1);
      vecs[4]  = mk(0,  0, 0, 1,  0, 1,  0, 0, 0, 0, 0);
      vecs[5]  = mk(1, 10, 1, 0,  0, 1,  0, 0, 0, 0, 0);
      vecs[6]  = mk(1, 11, 0, 0,  0, 1,  0, 0, 0, 0, 0);
      vecs[7]  = mk(1, 12, 0, 0,  0, 1,  0, 0, 0, 0, 0);
      vecs[8]  = mk(1, 13, 0, 0,  1, 1, 10, 11, 12, 13, 1);
      vecs[9]  = mk(1, 14, 0, 0,  1, 1, 10, 11, 12, 13, 1);
      vecs[10] = mk(1, 15, 1, 0,  1, 1, 10, 11, 12, 13, 1);
      vecs[11] = mk(1, 16, 1, 0,  1, 1, 10, 11, 12, 13, 1);
      vecs[12] = mk(1, 17, 1, 0,  1, 0, 10, 11, 12, 13, 1);
      vecs[13] = mk(1, 99, 1, 0,  1, 0, 10, 11, 12, 13, 1);
      vecs[14] = mk(0,  0, 0, 1,  1, 1, 14, 15, 16, 17, 0);
      vecs[15] = mk(0,  0, 0, 1,  0, 1,  0, 0, 0, 0, 0);
      vecs[16] = mk(1, 20, 0, 1,  0, 1,  0, 0, 0, 0, 0);
      vecs[17] = mk(1, 21, 1, 1,  0, 1,  0, 0, 0, 0, 0);
      vecs[18] = mk(1, 22, 0, 1,  0, 1,  0, 0, 0, 0, 0);
      vecs[19] = mk(1, 23, 1, 1,  1, 1, 20, 21, 22, 23, 0);
      vecs[20] = mk(0,  0, 0, 1,  0, 1,  0, 0, 0, 0, 0);

      // ---------------- reset ----------------
      do_reset();
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset in_ready",  64'(in_ready),  64'(1));
      chk_frame("reset", '0, '0, '0, '0, 1'b0);
      $display("reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);

      // ---------------- vector table ----------------
      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].iv, vecs[i].d, vecs[i].s, vecs[i].ordy);
         chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
         chk($sformatf("vec%0d in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
         if (vecs[i].e_ov)
            chk_frame($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3,
                      vecs[i].e_sg);
         $display("vec %0d: in=%0d/%0b ov=%0b ir=%0b out={%0d,%0d,%0d,%0d} sign=%0b",
                  i, vecs[i].d, vecs[i].iv, out_valid, in_ready,
                  out_data_0, out_data_1, out_data_2, out_data_3, poly_sign);
      end

      // ---------------- reset mid-frame ----------------
      step(1, 50, 1, 1);
      step(1, 51, 0, 1);
      rst = 1'b1;
      step(0, 0, 0, 1);
      rst = 1'b0;
      chk("midrst out_valid", 64'(out_valid), 64'(0));
      step(1, 60, 0, 1); chk("midrst s60 ov", 64'(out_valid), 64'(0));
      step(1, 61, 1, 1); chk("midrst s61 ov", 64'(out_valid), 64'(0));
      step(1, 62, 1, 1); chk("midrst s62 ov", 64'(out_valid), 64'(0));
      step(1, 63, 1, 1); chk("midrst s63 ov", 64'(out_valid), 64'(1));
      chk_frame("midrst", 60, 61, 62, 63, 1'b0);
      $display("midrst frame: {%0d,%0d,%0d,%0d} sign=%0b",
               out_data_0, out_data_1, out_data_2, out_data_3, poly_sign);
      step(0, 0, 0, 1); chk("midrst drain ov", 64'(out_valid), 64'(0));

`ifdef POLY_SPLIT_FLUSH_EN
      // ---------------- flush ----------------
      step(1, 7, 1, 1);
      step(1, 8, 0, 1);
      flush = 1'b1; in_valid = 1'b1; in_data = 9; in_sign = 1'b0;
      #1;
      chk("flush in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush ov", 64'(out_valid), 64'(1));
      chk_frame("flush", 7, 8, 0, 0, 1'b1);
      $display("flush frame: {%0d,%0d,%0d,%0d} sign=%0b",
               out_data_0, out_data_1, out_data_2, out_data_3, poly_sign);
      step(1, 30, 0, 1); chk("postflush ov", 64'(out_valid), 64'(0));
      step(1, 31, 0, 1);
      step(1, 32, 0, 1);
      step(1, 33, 0, 1); chk("postflush ov2", 64'(out_valid), 64'(1));
      chk_frame("postflush", 30, 31, 32, 33, 1'b0);
      flush = 1'b1;
      step(0, 0, 0, 1);
      flush = 1'b0;
      chk("flush phase0 noop ov", 64'(out_valid), 64'(0));
`endif

      // ---------------- randomized vs. frame model ----------------
      do_reset();
      nframes = 0;
      part_sign = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         // Completed-but-unconsumed frames: one in the output stage, at most
         // one more parked; input blocks only when both places are taken.
         chk("rnd out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
         chk("rnd in_ready",  64'(in_ready),  64'(exp_q.size() < 2));
         if (out_valid && exp_q.size() > 0) begin
            f = exp_q[0];
            chk_frame("rnd", f.d[0], f.d[1], f.d[2], f.d[3], f.s);
         end

         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = {1'($urandom), 32'($urandom)};
         in_sign   = 1'($urandom);
         out_ready = 1'($urandom);
         sx = in_valid & in_ready;
         fx = out_valid & out_ready;
         if (fx) begin
            $display("rnd frame %0d: {%0h,%0h,%0h,%0h} sign=%0b", nframes,
                     out_data_0, out_data_1, out_data_2, out_data_3, poly_sign);
            nframes++;
         end
         @(posedge clk); #1;

         if (fx && exp_q.size() > 0) void'(exp_q.pop_front());
         if (sx) begin
            if (part.size() == 0) part_sign = in_sign;
            part.push_back(in_data);
            if (part.size() == 4) begin
               for (int k = 0; k < 4; k++) f.d[k] = part[k];
               f.s = part_sign;
               exp_q.push_back(f);
               part.delete();
            end
         end
      end
      chk("rnd frames seen", 64'(nframes > 100), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
